// File: rtl/plab1_imul_pkg.sv
// Shared definitions for the variable-latency imul unit: request message
// layout, function codes and the multiplier FSM states.
package plab1_imul_pkg;

    typedef enum logic [1:0] {
        FnMul   = 2'b00,
        FnMulh  = 2'b01,
        FnMulhu = 2'b10,
        FnRsvd  = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSign = 2'd2,
        StDone = 2'd3
    } state_e;

    // Request message is {func[1:0], a[nbits-1:0], b[nbits-1:0]}.
    function automatic int unsigned req_msg_nbits(input int unsigned nbits);
        return 2 * nbits + 2;
    endfunction

    function automatic int unsigned tz_nbits(input int unsigned skip);
        return $clog2(skip + 1);
    endfunction

endpackage

// File: rtl/plab1_imul_count_tz.sv
// Trailing-zero counter over a p_skip-bit window; saturates at p_skip when the
// whole window is zero.
module plab1_imul_count_tz #(
    parameter int unsigned p_skip = 8
) (
    input  logic [p_skip-1:0]             b_i,
    output logic [$clog2(p_skip+1)-1:0]   z_o
);

    localparam int unsigned ZW = $clog2(p_skip + 1);

    always_comb begin
        z_o = ZW'(p_skip);
        // Scan from the top so the lowest set bit wins.
        for (int i = int'(p_skip) - 1; i >= 0; i--) begin
            if (b_i[i]) z_o = ZW'(i);
        end
    end

endmodule

// File: rtl/plab1_imul_int_mul_param_var_lat.sv
// Iterative zero-skipping shift-add multiplier with MUL/MULH/MULHU modes
// behind val/rdy request and response interfaces.
module plab1_imul_int_mul_param_var_lat
    import plab1_imul_pkg::*;
#(
    parameter int unsigned p_nbits = 32,
    parameter int unsigned p_skip  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 domain,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [2*p_nbits+1:0] in_msg,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [p_nbits-1:0]   out_msg
);

    localparam int unsigned MsgW = req_msg_nbits(p_nbits);
    localparam int unsigned ZW   = tz_nbits(p_skip);
    localparam int unsigned W2   = 2 * p_nbits;

    // The domain label is carried by the whole instance; no logic depends on it.
    logic unused_domain;
    assign unused_domain = domain;

    // Request unpack
    func_e              req_func;
    logic [p_nbits-1:0] req_a;
    logic [p_nbits-1:0] req_b;

    assign req_func = func_e'(in_msg[MsgW-1 -: 2]);
    assign req_a    = in_msg[W2-1 -: p_nbits];
    assign req_b    = in_msg[p_nbits-1:0];

    state_e             state_q, state_d;
    logic [W2-1:0]      a_q;
    logic [p_nbits-1:0] b_q;
    logic [W2-1:0]      acc_q;
    logic               neg_q;
    func_e              func_q;
    logic [p_nbits-1:0] result_q;

    // Datapath combinational terms
    logic [ZW-1:0]      z;
    logic [p_nbits-1:0] b_shift, b_next;
    logic [W2-1:0]      a_shift, a_next, acc_sum, acc_fin;
    logic [p_nbits-1:0] a_abs, b_abs;
    logic               is_mulh;

    plab1_imul_count_tz #(
        .p_skip (p_skip)
    ) u_count_tz (
        .b_i (b_q[p_skip-1:0]),
        .z_o (z)
    );

    assign is_mulh = (req_func == FnMulh);
    assign a_abs   = (is_mulh && req_a[p_nbits-1]) ? -req_a : req_a;
    assign b_abs   = (is_mulh && req_b[p_nbits-1]) ? -req_b : req_b;

    assign b_shift = b_q >> z;
    assign b_next  = b_shift >> 1;
    assign a_shift = a_q << z;
    assign a_next  = a_shift << 1;
    assign acc_sum = b_shift[0] ? acc_q + a_shift : acc_q;
    assign acc_fin = neg_q ? -acc_q : acc_q;

    // Control: next state and handshake outputs
    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_rdy = 1'b1;
                if (in_val) state_d = StCalc;
            end
            StCalc: if (b_next == '0) state_d = StSign;
            StSign: state_d = StDone;
            StDone: begin
                out_val = 1'b1;
                if (out_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            func_q   <= FnMul;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_val) begin
                        a_q    <= {{p_nbits{1'b0}}, a_abs};
                        b_q    <= b_abs;
                        acc_q  <= '0;
                        neg_q  <= is_mulh & (req_a[p_nbits-1] ^ req_b[p_nbits-1]);
                        func_q <= req_func;
                    end
                end
                StCalc: begin
                    acc_q <= acc_sum;
                    a_q   <= a_next;
                    b_q   <= b_next;
                end
                StSign: begin
                    acc_q    <= acc_fin;
                    result_q <= (func_q == FnMulh || func_q == FnMulhu) ?
                                acc_fin[W2-1:p_nbits] : acc_fin[p_nbits-1:0];
                end
                default: ;
            endcase
        end
    end

    assign out_msg = result_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown({in_val, in_rdy, out_val, out_rdy}))
                else $error("imul ctrl handshake signal is X");
        end
    end

endmodule
